// File: rtl/pipe_ctrl.sv
// Pipeline control for the 3-stage core: tracks X/M/W destination tags for forwarding,
// generates freeze/stall/flush for memory waits, redirects and load-use, and counts them.
module pipe_ctrl #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_regwe,
  input  logic [6:0]       id_opcode,
  input  logic             x_br_taken,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             flush_d,
  output logic             freeze_all,
  output logic [4:0]       old_rd,
  output logic             old_regwe,
  output logic [6:0]       old_opcode,
  output logic [4:0]       older_rd,
  output logic             older_regwe,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned RC_LAST_I = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RC_LAST_I);
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwe;
    logic [6:0] opcode;
  } tag_t;

  localparam tag_t BUBBLE = '{rd: 5'd0, regwe: 1'b0, opcode: 7'h00};

  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_RUN      = 2'd1,
    S_MEMWAIT  = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [RC_W-1:0] r_rst_cnt, w_rst_cnt_nxt;
  tag_t            r_x, r_m, r_w;
  tag_t            w_x_nxt, w_m_nxt, w_w_nxt;
  tag_t            w_id_tag;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic            w_stall_inc, w_flush_inc;
  logic            w_mem_wait, w_load_use;

  assign w_id_tag   = id_valid ? '{rd: id_rd, regwe: id_regwe, opcode: id_opcode} : BUBBLE;
  assign w_mem_wait = ((r_m.opcode == OPC_LOAD) || (r_m.opcode == OPC_STORE)) && !mem_ready;
  assign w_load_use = (r_x.opcode == OPC_LOAD) && r_x.regwe && (r_x.rd != 5'd0) && id_valid &&
                      ((id_rs1 == r_x.rd) || (id_rs2 == r_x.rd));

  // Next-state, tag movement and zero-latency pipeline controls
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_x_nxt       = r_x;
    w_m_nxt       = r_m;
    w_w_nxt       = r_w;
    stall_f       = 1'b0;
    flush_d       = 1'b0;
    freeze_all    = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    case (r_state)
      S_RESET: begin
        stall_f    = 1'b1;
        freeze_all = 1'b1;
        flush_d    = 1'b1;
        if (r_rst_cnt == RC_LAST) begin
          w_state_nxt   = S_RUN;
          w_rst_cnt_nxt = '0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RC_W'(1);
        end
      end
      S_RUN: begin
        if (w_mem_wait) begin
          stall_f     = 1'b1;
          freeze_all  = 1'b1;
          w_stall_inc = 1'b1;
          w_state_nxt = S_MEMWAIT;
        end else if (x_br_taken) begin
          w_w_nxt     = r_m;
          w_m_nxt     = r_x;
          w_x_nxt     = BUBBLE;
          flush_d     = 1'b1;
          w_flush_inc = 1'b1;
          w_state_nxt = S_REDIRECT;
        end else if (w_load_use) begin
          w_w_nxt     = r_m;
          w_m_nxt     = r_x;
          w_x_nxt     = BUBBLE;
          stall_f     = 1'b1;
          w_flush_inc = 1'b1;
        end else begin
          w_w_nxt = r_m;
          w_m_nxt = r_x;
          w_x_nxt = w_id_tag;
        end
      end
      S_MEMWAIT: begin
        if (w_mem_wait) begin
          stall_f     = 1'b1;
          freeze_all  = 1'b1;
          w_stall_inc = 1'b1;
        end else begin
          w_w_nxt     = r_m;
          w_m_nxt     = r_x;
          w_x_nxt     = w_id_tag;
          w_state_nxt = S_RUN;
        end
      end
      S_REDIRECT: begin
        // A memory wait holds the wrong-path instruction in ID; squash it once released
        if (w_mem_wait) begin
          stall_f     = 1'b1;
          freeze_all  = 1'b1;
          w_stall_inc = 1'b1;
        end else begin
          w_w_nxt     = r_m;
          w_m_nxt     = r_x;
          w_x_nxt     = BUBBLE;
          flush_d     = 1'b1;
          w_flush_inc = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  // State, tag and saturating counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RESET;
      r_rst_cnt   <= '0;
      r_x         <= BUBBLE;
      r_m         <= BUBBLE;
      r_w         <= BUBBLE;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
      r_x       <= w_x_nxt;
      r_m       <= w_m_nxt;
      r_w       <= w_w_nxt;
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign old_rd      = r_m.rd;
  assign old_regwe   = r_m.regwe;
  assign old_opcode  = r_m.opcode;
  assign older_rd    = r_w.rd;
  assign older_regwe = r_w.regwe;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset hold, tag flow, memory wait, branch redirect,
// load-use interlock and counter saturation with mid-wait reset.
module tb_pipe_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rd, id_rs1, id_rs2;
  logic          id_regwe;
  logic [6:0]    id_opcode;
  logic          x_br_taken;
  logic          mem_ready;
  logic          stall_f, flush_d, freeze_all;
  logic [4:0]    old_rd, older_rd;
  logic          old_regwe, older_regwe;
  logic [6:0]    old_opcode;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_ctrl #(.RST_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_regwe(id_regwe), .id_opcode(id_opcode), .x_br_taken(x_br_taken),
    .mem_ready(mem_ready), .stall_f(stall_f), .flush_d(flush_d), .freeze_all(freeze_all),
    .old_rd(old_rd), .old_regwe(old_regwe), .old_opcode(old_opcode), .older_rd(older_rd),
    .older_regwe(older_regwe), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic we, input logic [6:0] opc);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_regwe = we; id_opcode = opc;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 7'h00);
  endtask

  task automatic reset_dut();
    rst = 1'b1; idle(); x_br_taken = 1'b0; mem_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1; idle(); x_br_taken = 1'b0; mem_ready = 1'b1;

    // Reset: held 3 cycles, then exactly 2 frozen cycles
    repeat (3) tick();
    rst = 1'b0; #1;
    chk("rst_stall0", 32'(stall_f), 32'd1);
    chk("rst_freeze0", 32'(freeze_all), 32'd1);
    chk("rst_flush0", 32'(flush_d), 32'd1);
    chk("rst_old_rd", 32'(old_rd), 32'd0);
    chk("rst_older_rd", 32'(older_rd), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    tick(); #1;
    chk("rst_stall1", 32'(stall_f), 32'd1);
    tick(); #1;
    chk("run_stall", 32'(stall_f), 32'd0);
    chk("run_freeze", 32'(freeze_all), 32'd0);
    chk("run_flush", 32'(flush_d), 32'd0);

    // Tag flow: ADDI x5 in ID at t
    set_id(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, OP_IMM); #1;
    chk("tf_stall", 32'(stall_f), 32'd0);
    tick(); idle(); #1;
    chk("tf_old_t1", 32'(old_rd), 32'd0);
    tick(); #1;
    chk("tf_old_rd", 32'(old_rd), 32'd5);
    chk("tf_old_we", 32'(old_regwe), 32'd1);
    chk("tf_old_opc", 32'(old_opcode), 32'(OP_IMM));
    tick(); #1;
    chk("tf_older_rd", 32'(older_rd), 32'd5);
    chk("tf_older_we", 32'(older_regwe), 32'd1);
    chk("tf_old_bub", 32'(old_regwe), 32'd0);

    // Memory wait: LW x7 in M, ADDI x9 in X, mem_ready low 4 cycles
    reset_dut();
    set_id(1'b1, 5'd7, 5'd1, 5'd0, 1'b1, OP_LOAD);
    tick(); set_id(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, OP_IMM);
    tick(); set_id(1'b1, 5'd10, 5'd0, 5'd0, 1'b1, OP_IMM);
    mem_ready = 1'b0; x_br_taken = 1'b1; #1;
    chk("mw_br_noflush", 32'(flush_d), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin tick(); x_br_taken = 1'b0; #1; end
      chk($sformatf("mw_freeze%0d", i), 32'(freeze_all), 32'd1);
      chk($sformatf("mw_stall%0d", i), 32'(stall_f), 32'd1);
      chk($sformatf("mw_old%0d", i), 32'(old_rd), 32'd7);
    end
    tick(); mem_ready = 1'b1; #1;
    chk("mw_release_freeze", 32'(freeze_all), 32'd0);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);
    chk("mw_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("mw_old_held", 32'(old_rd), 32'd7);
    tick(); idle(); #1;
    chk("mw_adv_old", 32'(old_rd), 32'd9);
    chk("mw_adv_older", 32'(older_rd), 32'd7);
    chk("mw_adv_stall", 32'(stall_f), 32'd0);

    // Branch redirect: JAL x1 in X with x_br_taken pulse
    reset_dut();
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, OP_JAL);
    tick(); set_id(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, OP_IMM); x_br_taken = 1'b1; #1;
    chk("br_flush0", 32'(flush_d), 32'd1);
    chk("br_stall0", 32'(stall_f), 32'd0);
    tick(); set_id(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, OP_IMM); x_br_taken = 1'b0; #1;
    chk("br_flush1", 32'(flush_d), 32'd1);
    chk("br_old_jal", 32'(old_rd), 32'd1);
    tick(); idle(); #1;
    chk("br_flush2", 32'(flush_d), 32'd0);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd2);
    chk("br_bub1_we", 32'(old_regwe), 32'd0);
    chk("br_older_jal", 32'(older_rd), 32'd1);
    tick(); #1;
    chk("br_bub2_rd", 32'(old_rd), 32'd0);
    chk("br_bub2_we", 32'(old_regwe), 32'd0);

    // Load-use: LW x3 in X, ADD x4,x3,x1 in ID
    reset_dut();
    set_id(1'b1, 5'd3, 5'd2, 5'd0, 1'b1, OP_LOAD);
    tick(); set_id(1'b1, 5'd4, 5'd3, 5'd1, 1'b1, OP_REG); #1;
    chk("lu_stall", 32'(stall_f), 32'd1);
    chk("lu_noflush", 32'(flush_d), 32'd0);
    chk("lu_nofreeze", 32'(freeze_all), 32'd0);
    tick(); #1;
    chk("lu_stall_done", 32'(stall_f), 32'd0);
    chk("lu_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("lu_old_lw", 32'(old_rd), 32'd3);
    tick(); idle(); #1;
    chk("lu_bubble", 32'(old_rd), 32'd0);
    tick(); #1;
    chk("lu_add_old", 32'(old_rd), 32'd4);
    // Same pattern against x0 must not interlock
    set_id(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, OP_LOAD);
    tick(); set_id(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, OP_REG); #1;
    chk("lu_x0_stall", 32'(stall_f), 32'd0);
    tick(); idle(); #1;
    chk("lu_x0_cnt", 32'(flush_cnt), 32'd1);

    // Branch and load-use together: branch wins, one flush only
    reset_dut();
    set_id(1'b1, 5'd3, 5'd2, 5'd0, 1'b1, OP_LOAD);
    tick(); set_id(1'b1, 5'd4, 5'd3, 5'd1, 1'b1, OP_REG); x_br_taken = 1'b1; #1;
    chk("brlu_stall", 32'(stall_f), 32'd0);
    chk("brlu_flush", 32'(flush_d), 32'd1);
    tick(); x_br_taken = 1'b0; #1;
    chk("brlu_cnt", 32'(flush_cnt), 32'd1);

    // Saturation of a 4-bit stall counter, then reset mid-wait
    reset_dut();
    set_id(1'b1, 5'd7, 5'd1, 5'd0, 1'b1, OP_LOAD);
    tick(); idle();
    tick(); mem_ready = 1'b0;
    repeat (20) tick();
    #1;
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    chk("sat_freeze", 32'(freeze_all), 32'd1);
    rst = 1'b1;
    tick(); #1;
    chk("rstmw_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rstmw_old_rd", 32'(old_rd), 32'd0);
    chk("rstmw_stall", 32'(stall_f), 32'd1);
    chk("rstmw_flush", 32'(flush_d), 32'd1);
    rst = 1'b0; mem_ready = 1'b1;
    repeat (2) tick();
    #1;
    chk("rstmw_run", 32'(stall_f), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
